acesso_memoria: RTL and testbench

ACESSO_MEMORIA -- requirements
Module: acesso_memoria
Downstream memory-access stage: consumes the 64-bit ULA result (address or operation result) and store data, drives the data-memory bus, and returns the writeback value.

---
 rtl/acesso_memoria.sv | 134 +++++++++++++
 tb/tb_acesso_memoria.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/acesso_memoria.sv
// rtl/acesso_memoria.sv - memory-access stage: pass-through, load and store with bus timeout
// Optional build macro ALIGN_CHECK_EN: reject loads/stores whose address is not 8-byte aligned.
module acesso_memoria #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mem_op,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [63:0] result,
  output logic        done,
  output logic        busy,
  output logic        erro
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [63:0]   result_q, result_d;
  logic          erro_q, erro_d;

  logic          is_mem_op;

  assign is_mem_op = (mem_op == 2'b01) || (mem_op == 2'b10);

  // Bus signals come straight from the state so reset drops mem_req without waiting for a clock.
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? addr_q  : 64'd0;
  assign mem_wdata = mem_req ? wdata_q : 64'd0;
  assign done      = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign erro      = erro_q;

  // Next-state, operand capture, wait counting and writeback selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    result_d = result_q;
    erro_d   = erro_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = addr;
          wdata_d = store_data;
          we_d    = (mem_op == 2'b10);
          cnt_d   = '0;
          if (is_mem_op) begin
`ifdef ALIGN_CHECK_EN
            if (addr[2:0] != 3'd0) begin
              state_d  = DONE;
              result_d = 64'd0;
              erro_d   = 1'b1;
            end else begin
              state_d = ACCESS;
            end
`else
            state_d = ACCESS;
`endif
          end else begin
            state_d  = DONE;
            result_d = addr;
            erro_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        // A ready on the timeout edge still counts as a normal completion.
        if (mem_ready) begin
          state_d  = DONE;
          result_d = we_q ? addr_q : mem_rdata;
          erro_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          result_d = 64'd0;
          erro_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      we_q     <= 1'b0;
      result_q <= 64'd0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      result_q <= result_d;
      erro_q   <= erro_d;
    end
  end

endmodule

// File: tb/tb_acesso_memoria.sv
// tb/tb_acesso_memoria.sv - directed self-checking bench for acesso_memoria
module tb_acesso_memoria;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mem_op;
  logic [63:0] addr;
  logic [63:0] store_data;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] result;
  logic        done;
  logic        busy;
  logic        erro;

  int checks = 0;
  int errors = 0;
  int n;

  acesso_memoria #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_op     (mem_op),
    .addr       (addr),
    .store_data (store_data),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .result     (result),
    .done       (done),
    .busy       (busy),
    .erro       (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] sd);
    @(negedge clk);
    start      = 1'b1;
    mem_op     = op;
    addr       = a;
    store_data = sd;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mem_op = 2'b00; addr = 64'd0;
    store_data = 64'd0; mem_rdata = 64'd0; mem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_done",    {63'd0, done},    64'd0);
    chk("rst_busy",    {63'd0, busy},    64'd0);
    chk("rst_erro",    {63'd0, erro},    64'd0);
    chk("rst_result",  result,           64'd0);
    chk("rst_mem_addr", mem_addr,        64'd0);
    rst_n = 1'b1;

    // pass-through, op 00
    issue(2'b00, 64'h1234, 64'd0);
    @(negedge clk); start = 1'b0; addr = 64'hFFFF_0000;
    chk("pt_done",    {63'd0, done},    64'd1);
    chk("pt_result",  result,           64'h1234);
    chk("pt_erro",    {63'd0, erro},    64'd0);
    chk("pt_mem_req", {63'd0, mem_req}, 64'd0);
    chk("pt_busy",    {63'd0, busy},    64'd1);
    @(negedge clk);
    chk("pt_done_pulse", {63'd0, done}, 64'd0);
    chk("pt_idle",    {63'd0, busy},    64'd0);
    chk("pt_hold",    result,           64'h1234);

    // op 11 behaves as pass-through
    issue(2'b11, 64'h55, 64'd0);
    @(negedge clk); start = 1'b0;
    chk("op11_done",    {63'd0, done},    64'd1);
    chk("op11_result",  result,           64'h55);
    chk("op11_mem_req", {63'd0, mem_req}, 64'd0);

    // load with three wait cycles
    issue(2'b01, 64'h100, 64'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); start = 1'b0; addr = 64'hFFFF;
      if (i == 4) begin mem_ready = 1'b1; mem_rdata = 64'hDEADBEEF; end
      chk("ld_mem_req",  {63'd0, mem_req}, 64'd1);
      chk("ld_mem_addr", mem_addr,         64'h100);
      chk("ld_mem_we",   {63'd0, mem_we},  64'd0);
      chk("ld_no_done",  {63'd0, done},    64'd0);
    end
    @(negedge clk); mem_ready = 1'b0;
    chk("ld_done",     {63'd0, done},    64'd1);
    chk("ld_result",   result,           64'hDEADBEEF);
    chk("ld_erro",     {63'd0, erro},    64'd0);
    chk("ld_req_off",  {63'd0, mem_req}, 64'd0);
    chk("ld_addr_off", mem_addr,         64'd0);

    // store with ready already high (ignored in IDLE)
    issue(2'b10, 64'h200, 64'hAA55);
    mem_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("st_done_early", {63'd0, done},   64'd0);
    chk("st_mem_req",  {63'd0, mem_req},  64'd1);
    chk("st_mem_we",   {63'd0, mem_we},   64'd1);
    chk("st_mem_wdata", mem_wdata,        64'hAA55);
    chk("st_mem_addr", mem_addr,          64'h200);
    @(negedge clk); mem_ready = 1'b0;
    chk("st_done",     {63'd0, done},     64'd1);
    chk("st_result",   result,            64'h200);
    chk("st_we_off",   {63'd0, mem_we},   64'd0);
    chk("st_wdata_off", mem_wdata,        64'd0);

    // timeout with a second start while busy
    issue(2'b01, 64'h300, 64'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = (i == 2);
      if (mem_req) n++;
      if (done) break;
    end
    start = 1'b0;
    chk("to_req_cycles", 64'(n),        64'd16);
    chk("to_done",     {63'd0, done},   64'd1);
    chk("to_erro",     {63'd0, erro},   64'd1);
    chk("to_result",   result,          64'd0);
    @(negedge clk);
    chk("to_no_queue_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("to_no_queue_req",  {63'd0, mem_req}, 64'd0);
    chk("to_erro_hold", {63'd0, erro},  64'd1);

    // ready on the timeout edge wins
    issue(2'b01, 64'h308, 64'd0);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk); start = 1'b0;
    end
    @(negedge clk); mem_ready = 1'b1; mem_rdata = 64'h77;
    chk("tie_mem_req", {63'd0, mem_req}, 64'd1);
    @(negedge clk); mem_ready = 1'b0;
    chk("tie_done",    {63'd0, done},   64'd1);
    chk("tie_erro",    {63'd0, erro},   64'd0);
    chk("tie_result",  result,          64'h77);

    // reset in the second access cycle
    issue(2'b01, 64'h400, 64'd0);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("rm_req_before", {63'd0, mem_req}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rm_req_async",  {63'd0, mem_req}, 64'd0);
    chk("rm_busy_async", {63'd0, busy},    64'd0);
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || mem_req) n++;
    end
    chk("rm_no_pending", 64'(n), 64'd0);
    issue(2'b01, 64'h408, 64'd0);
    mem_ready = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
    @(negedge clk); start = 1'b0;
    chk("rm_new_req",  {63'd0, mem_req}, 64'd1);
    @(negedge clk); mem_ready = 1'b0;
    chk("rm_new_done", {63'd0, done},    64'd1);
    chk("rm_new_result", result,         64'h1122_3344_5566_7788);

    // misaligned load
    issue(2'b01, 64'h103, 64'd0);
    @(negedge clk); start = 1'b0;
`ifdef ALIGN_CHECK_EN
    chk("al_done",    {63'd0, done},    64'd1);
    chk("al_erro",    {63'd0, erro},    64'd1);
    chk("al_mem_req", {63'd0, mem_req}, 64'd0);
    chk("al_result",  result,           64'd0);
`else
    chk("al_mem_req",  {63'd0, mem_req}, 64'd1);
    chk("al_mem_addr", mem_addr,         64'h103);
    mem_ready = 1'b1; mem_rdata = 64'hCAFE;
    @(negedge clk); mem_ready = 1'b0;
    chk("al_done",    {63'd0, done},    64'd1);
    chk("al_erro",    {63'd0, erro},    64'd0);
    chk("al_result",  result,           64'hCAFE);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
